rom_burst_reader: RTL and testbench

Read initiator for the team's single-port synchronous ROM, which registers its read data one cycle after the address is presented with its enable high. On a start command the block issues a burst of sequential reads from a start address for a given length, wrapping at the top of the address space. It presents each returned word on a valid/ready output stream and keeps a running 8-bit checksum of the accepted words. It sits between a control FSM or CPU and the ROM, owning the ROM's addr/enable pins.

---
 rtl/rom_burst_reader.sv | 113 +++++++++++
 tb/tb_rom_burst_reader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader.sv
// Burst read initiator for a single-port synchronous ROM with registered read data.
// Issues sequential wrapping reads and streams each word out over valid/ready with a running checksum.
module rom_burst_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [LEN_W-1:0]    r_remaining;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic [DATA_W-1:0]   r_out_data;
  logic [DATA_W-1:0]   r_checksum;
  logic                w_accept;
  logic                w_last;
  logic                w_len_zero;

  assign w_accept   = (r_state == S_HOLD) && out_ready;
  assign w_last     = (r_remaining == LEN_W'(1));
  assign w_len_zero = (length == '0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = w_len_zero ? S_DONE : S_READ;
        end
      end
      S_READ:  w_state_next = S_CAPT;
      S_CAPT:  w_state_next = S_HOLD;
      S_HOLD: begin
        if (w_accept) begin
          w_state_next = w_last ? S_DONE : S_READ;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // rom_addr is loaded only on the way into READ, so it holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_rom_addr  <= '0;
      r_out_data  <= '0;
      r_checksum  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur_addr  <= start_addr;
            r_remaining <= length;
            r_checksum  <= '0;
            if (!w_len_zero) begin
              r_rom_addr <= start_addr;
            end
          end
        end
        S_CAPT: r_out_data <= rom_data;
        S_HOLD: begin
          if (w_accept) begin
            r_checksum  <= r_checksum + r_out_data;
            r_cur_addr  <= r_cur_addr + ADDR_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
            if (!w_last) begin
              r_rom_addr <= r_cur_addr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_addr  = r_rom_addr;
  assign rom_en    = (r_state == S_READ);
  assign out_data  = r_out_data;
  assign out_valid = (r_state == S_HOLD);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign checksum  = r_checksum;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader: ROM model with mem[i]=i, table of bursts,
// address/data scoreboards fed at start and drained by a negedge monitor.
module tb_rom_burst_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] start_addr = '0;
  logic [4:0] length = '0;
  logic [3:0] rom_addr;
  logic       rom_en;
  logic [7:0] rom_data = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  rom_burst_reader #(.ADDR_W(4), .DATA_W(8), .LEN_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .rom_addr   (rom_addr),
    .rom_en     (rom_en),
    .rom_data   (rom_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  logic [7:0] rom_mem [16];
  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'(i);
  end
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_mem[rom_addr];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  int         exp_addr_q[$];
  int         exp_data_q[$];
  int         rom_en_cnt, valid_cnt, done_cnt, busy_cnt, first_valid_cyc;
  logic       prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rom_en) begin
        rom_en_cnt++;
        if (exp_addr_q.size() == 0) chk("rom_en_unexpected", 1, 0);
        else chk("rom_addr", rom_addr, exp_addr_q.pop_front());
      end
      if (out_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_valid && !prev_ready) chk("out_data_stable", out_data, prev_data);
        if (out_ready) begin
          if (exp_data_q.size() == 0) chk("word_unexpected", 1, 0);
          else chk("out_data", out_data, exp_data_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        chk("busy_with_done", busy, 1);
      end
      if (busy) busy_cnt++;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
    end
  end

  task automatic clear_counts();
    rom_en_cnt = 0; valid_cnt = 0; done_cnt = 0; busy_cnt = 0; first_valid_cyc = -1;
  endtask

  task automatic load_model(input int a, input int l);
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < l; i++) begin
      exp_addr_q.push_back((a + i) % 16);
      exp_data_q.push_back(int'(rom_mem[(a + i) % 16]));
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_rom_en"}, rom_en, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_checksum"}, checksum, 0);
  endtask

  // mode 0: ready held 1; mode 1: ready toggles each cycle.
  task automatic run_burst(input int a, input int l, input int mode, input bit mid, input int exp_cs);
    int start_cyc;
    int waited;
    load_model(a, l);
    clear_counts();
    @(posedge clk); #1;
    start = 1'b1; start_addr = 4'(a); length = 5'(l); out_ready = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; start_addr = 4'hA; length = 5'd9;
    waited = 0;
    while (done_cnt == 0 && waited < 300) begin
      if (mode == 1) out_ready = ~out_ready;
      else out_ready = 1'b1;
      start = (mid && (waited == 4 || waited == 5));
      @(posedge clk); #1;
      waited++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (waited >= 300) chk("done_timeout", 1, 0);
    repeat (8) @(posedge clk);
    #1;
    $display("burst addr=%0d len=%0d mode=%0d mid=%0d -> checksum=%0d words_left=%0d", a, l, mode, mid, checksum, exp_data_q.size());
    chk("checksum", checksum, exp_cs);
    chk("words_left", exp_data_q.size(), 0);
    chk("rom_reads", rom_en_cnt, l);
    chk("done_pulses", done_cnt, 1);
    chk("busy_after", busy, 0);
    if (l == 0) begin
      chk("len0_valid_cnt", valid_cnt, 0);
      chk("len0_busy_cycles", busy_cnt, 1);
    end else if (mode == 0) begin
      chk("first_valid_latency", first_valid_cyc - start_cyc, 3);
      chk("busy_cycles", busy_cnt, 3 * l + 1);
    end
  endtask

  typedef struct {
    int addr;
    int len;
    int mode;
    bit mid;
    int exp_cs;
  } vec_t;

  vec_t vecs[6];
  int   waited;

  initial begin
    vecs[0] = '{addr: 3,  len: 4,  mode: 0, mid: 1'b0, exp_cs: 18};
    vecs[1] = '{addr: 14, len: 4,  mode: 0, mid: 1'b0, exp_cs: 30};
    vecs[2] = '{addr: 0,  len: 16, mode: 1, mid: 1'b0, exp_cs: 120};
    vecs[3] = '{addr: 0,  len: 0,  mode: 0, mid: 1'b0, exp_cs: 0};
    vecs[4] = '{addr: 7,  len: 3,  mode: 0, mid: 1'b1, exp_cs: 24};
    vecs[5] = '{addr: 9,  len: 16, mode: 0, mid: 1'b0, exp_cs: 120};

    clear_counts();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");

    for (int v = 0; v < 6; v++) begin
      run_burst(vecs[v].addr, vecs[v].len, vecs[v].mode, vecs[v].mid, vecs[v].exp_cs);
    end

    // Reset while holding a word with out_ready low.
    load_model(2, 3);
    clear_counts();
    @(posedge clk); #1;
    start = 1'b1; start_addr = 4'd2; length = 5'd3; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (!out_valid && waited < 20) begin @(posedge clk); #1; waited++; end
    chk("hold1_reached", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    waited = 0;
    while (!out_valid && waited < 20) begin @(posedge clk); #1; waited++; end
    chk("hold2_reached", out_valid, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_checksum", checksum, 2);
    chk("hold_out_data", out_data, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    $display("reset in HOLD -> busy=%0d out_valid=%0d out_data=%0d checksum=%0d", busy, out_valid, out_data, checksum);
    check_idle_zero("hold_reset");
    run_burst(5, 1, 0, 1'b0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
